aib_axil_arbiter: RTL and testbench

AIB_AXIL_ARBITER -- requirements
Module: aib_axil_arbiter

---
 rtl/aib_axil_pkg.sv | 21 ++
 rtl/aib_rr_arb2.sv | 31 +++
 rtl/aib_axil_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_aib_axil_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aib_axil_pkg.sv
// Shared types and constants for the two-requester AXI-Lite arbiter.
package aib_axil_pkg;

    localparam int NREQ = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FWD  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_FWD  = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/aib_rr_arb2.sv
// Two-input round-robin arbiter; grant is combinational, last-grant pointer is registered.
module aib_rr_arb2 (
    input  logic       clk_wr,
    input  logic       rst_wr,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    // last_q = index granted most recently; reset to 1 so port 0 wins the first tie
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            last_q <= 1'b1;
        end else if (adv && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/aib_axil_arbiter.sv
// Arbitrates two AXI-Lite requesters onto one master port; write and read paths
// are independent, each with one outstanding transaction.
module aib_axil_arbiter
    import aib_axil_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                   clk_wr,
    input  logic                   rst_wr,
    // requester side, index i at bits [i*W +: W]
    input  logic [NREQ*ADDR_W-1:0] s_awaddr,
    input  logic [NREQ-1:0]        s_awvalid,
    output logic [NREQ-1:0]        s_awready,
    input  logic [NREQ*DATA_W-1:0] s_wdata,
    input  logic [NREQ*STRB_W-1:0] s_wstrb,
    input  logic [NREQ-1:0]        s_wvalid,
    output logic [NREQ-1:0]        s_wready,
    output logic [NREQ*2-1:0]      s_bresp,
    output logic [NREQ-1:0]        s_bvalid,
    input  logic [NREQ-1:0]        s_bready,
    input  logic [NREQ*ADDR_W-1:0] s_araddr,
    input  logic [NREQ-1:0]        s_arvalid,
    output logic [NREQ-1:0]        s_arready,
    output logic [NREQ*DATA_W-1:0] s_rdata,
    output logic [NREQ*2-1:0]      s_rresp,
    output logic [NREQ-1:0]        s_rvalid,
    input  logic [NREQ-1:0]        s_rready,
    // master side
    output logic [ADDR_W-1:0]      m_awaddr,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [DATA_W-1:0]      m_wdata,
    output logic [STRB_W-1:0]      m_wstrb,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [1:0]             m_bresp,
    input  logic                   m_bvalid,
    output logic                   m_bready,
    output logic [ADDR_W-1:0]      m_araddr,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    // status
    output logic [NREQ-1:0]        wr_grant,
    output logic [NREQ-1:0]        rd_grant,
    output logic [15:0]            wr_txn_cnt,
    output logic [15:0]            rd_txn_cnt,
    output logic [1:0]             wr_state_dbg,
    output logic [1:0]             rd_state_dbg
);

    // Every channel transfers on a cycle where valid and ready are both high at
    // the rising edge; valid never waits on ready, and this block only ever
    // gates the granted requester's valid/ready through to the other side.

    wr_state_t        wr_state_q, wr_state_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic [NREQ-1:0]  wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [NREQ-1:0]  wr_arb_gnt, rd_arb_gnt;
    logic             wr_arb_adv, rd_arb_adv;
    logic             wr_sel, rd_sel, wr_fwd, wr_resp, rd_fwd, rd_resp;
    logic             aw_hs, w_hs, wr_done, rd_done;

    aib_rr_arb2 u_wr_arb (
        .clk_wr (clk_wr),
        .rst_wr (rst_wr),
        .req    (s_awvalid),
        .adv    (wr_arb_adv),
        .gnt    (wr_arb_gnt)
    );

    aib_rr_arb2 u_rd_arb (
        .clk_wr (clk_wr),
        .rst_wr (rst_wr),
        .req    (s_arvalid),
        .adv    (rd_arb_adv),
        .gnt    (rd_arb_gnt)
    );

    assign wr_sel  = wr_grant_q[1];
    assign rd_sel  = rd_grant_q[1];
    assign wr_fwd  = (wr_state_q == W_FWD);
    assign wr_resp = (wr_state_q == W_RESP);
    assign rd_fwd  = (rd_state_q == R_FWD);
    assign rd_resp = (rd_state_q == R_RESP);

    // Write channel routing
    assign m_awaddr  = (wr_grant_q == 2'b00) ? '0 :
                       (wr_sel ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0]);
    assign m_awvalid = wr_fwd & ~aw_done_q & s_awvalid[wr_sel];
    assign s_awready = {NREQ{wr_fwd & ~aw_done_q & m_awready}} & wr_grant_q;
    assign m_wdata   = (wr_grant_q == 2'b00) ? '0 :
                       (wr_sel ? s_wdata[2*DATA_W-1:DATA_W] : s_wdata[DATA_W-1:0]);
    assign m_wstrb   = (wr_grant_q == 2'b00) ? '0 :
                       (wr_sel ? s_wstrb[2*STRB_W-1:STRB_W] : s_wstrb[STRB_W-1:0]);
    assign m_wvalid  = wr_fwd & ~w_done_q & s_wvalid[wr_sel];
    assign s_wready  = {NREQ{wr_fwd & ~w_done_q & m_wready}} & wr_grant_q;
    assign m_bready  = wr_resp & s_bready[wr_sel];
    assign s_bvalid  = {NREQ{wr_resp & m_bvalid}} & wr_grant_q;
    assign s_bresp   = !wr_resp ? '0 : (wr_sel ? {m_bresp, 2'b00} : {2'b00, m_bresp});

    assign aw_hs   = m_awvalid & m_awready;
    assign w_hs    = m_wvalid & m_wready;
    assign wr_done = wr_resp & m_bvalid & m_bready;

    // Read channel routing
    assign m_araddr  = (rd_grant_q == 2'b00) ? '0 :
                       (rd_sel ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0]);
    assign m_arvalid = rd_fwd & s_arvalid[rd_sel];
    assign s_arready = {NREQ{rd_fwd & m_arready}} & rd_grant_q;
    assign m_rready  = rd_resp & s_rready[rd_sel];
    assign s_rvalid  = {NREQ{rd_resp & m_rvalid}} & rd_grant_q;
    assign s_rdata   = !rd_resp ? '0 :
                       (rd_sel ? {m_rdata, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, m_rdata});
    assign s_rresp   = !rd_resp ? '0 : (rd_sel ? {m_rresp, 2'b00} : {2'b00, m_rresp});

    assign rd_done = rd_resp & m_rvalid & m_rready;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        wr_arb_adv = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (s_awvalid != 2'b00) begin
                    wr_arb_adv = 1'b1;
                    wr_grant_d = wr_arb_gnt;
                    wr_state_d = W_FWD;
                end
            end
            W_FWD: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // AW and W may finish in either order or together
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (wr_done) begin
                    wr_grant_d = 2'b00;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_arb_adv = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (s_arvalid != 2'b00) begin
                    rd_arb_adv = 1'b1;
                    rd_grant_d = rd_arb_gnt;
                    rd_state_d = R_FWD;
                end
            end
            R_FWD: begin
                if (m_arvalid && m_arready) rd_state_d = R_RESP;
            end
            R_RESP: begin
                if (rd_done) begin
                    rd_grant_d = 2'b00;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_grant_q <= 2'b00;
            rd_grant_q <= 2'b00;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_txn_cnt <= 16'd0;
            rd_txn_cnt <= 16'd0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            if (wr_done) wr_txn_cnt <= wr_txn_cnt + 16'd1;
            if (rd_done) rd_txn_cnt <= rd_txn_cnt + 16'd1;
        end
    end

    assign wr_grant     = wr_grant_q;
    assign rd_grant     = rd_grant_q;
    assign wr_state_dbg = wr_state_q;
    assign rd_state_dbg = rd_state_q;

endmodule

// File: tb/tb_aib_axil_arbiter.sv
// Directed bench for aib_axil_arbiter: single write, contention, concurrency,
// W-before-AW, reset in W_RESP and counter wrap.
module tb_aib_axil_arbiter;
    import aib_axil_pkg::*;

    logic        clk_wr, rst_wr;
    logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [7:0]  s_wstrb;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [3:0]  s_bresp, s_rresp;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;
    logic [1:0]  wr_grant, rd_grant, wr_state_dbg, rd_state_dbg;
    logic [15:0] wr_txn_cnt, rd_txn_cnt;

    int checks = 0;
    int errors = 0;
    int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    int aw0, w0, b0;

    aib_axil_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .wr_grant(wr_grant), .rd_grant(rd_grant),
        .wr_txn_cnt(wr_txn_cnt), .rd_txn_cnt(rd_txn_cnt),
        .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
    );

    // clock / reset
    initial clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    // handshake monitor on the master port
    always @(posedge clk_wr) begin
        if (m_awvalid && m_awready) aw_hs_n <= aw_hs_n + 1;
        if (m_wvalid && m_wready)   w_hs_n  <= w_hs_n + 1;
        if (m_bvalid && m_bready)   b_hs_n  <= b_hs_n + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        s_awaddr = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0;
        s_bready = '0; s_araddr = '0; s_arvalid = '0; s_rready = '0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_wr);
        clear_inputs();
        rst_wr = 1'b1;
        @(negedge clk_wr);
        rst_wr = 1'b0;
    endtask

    // one clean write from port p with both slave readies high
    task automatic wr_txn(input int p, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input string tag);
        logic [1:0] g;
        g = 2'b01 << p;
        @(negedge clk_wr);
        s_awaddr[p*32 +: 32] = addr;
        s_wdata[p*32 +: 32]  = data;
        s_wstrb[p*4 +: 4]    = 4'hF;
        s_awvalid[p] = 1'b1;
        s_wvalid[p]  = 1'b1;
        s_bready[p]  = 1'b1;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        #1;
        chk({tag, "_awvalid_n"}, m_awvalid, 1'b0);
        @(negedge clk_wr); #1;
        chk({tag, "_grant"}, wr_grant, g);
        chk({tag, "_awvalid_n1"}, m_awvalid, 1'b1);
        chk({tag, "_awaddr"}, m_awaddr, addr);
        chk({tag, "_wdata"}, m_wdata, data);
        @(negedge clk_wr);
        s_awvalid[p] = 1'b0;
        s_wvalid[p]  = 1'b0;
        m_bvalid = 1'b1;
        m_bresp  = resp;
        #1;
        chk({tag, "_bvalid"}, s_bvalid, g);
        chk({tag, "_bresp"}, s_bresp, {2'b00, resp} << (2 * p));
        @(negedge clk_wr);
        m_bvalid = 1'b0;
        m_bresp  = '0;
        s_bready[p] = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_wr = 1'b1;
        repeat (2) @(negedge clk_wr);
        do_reset();
        #1;
        chk("rst_wr_grant", wr_grant, 2'b00);
        chk("rst_rd_grant", rd_grant, 2'b00);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        chk("rst_cnts", {wr_txn_cnt, rd_txn_cnt}, 32'h0);

        // single write from port 0
        wr_txn(0, 32'hA000_0000, 32'hDEAD_BEEF, RESP_OKAY, "single");
        chk("single_wr_cnt", wr_txn_cnt, 16'd1);
        chk("single_strb_idle", m_wstrb, 4'h0);

        // contention: both ports write in the same cycle
        do_reset();
        @(negedge clk_wr);
        s_awaddr = {32'h0000_1111, 32'h0000_0000};
        s_wdata  = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        s_wstrb  = 8'hFF;
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
        m_awready = 1'b1; m_wready = 1'b1;
        #1 chk("cont_grant_idle", wr_grant, 2'b00);
        @(negedge clk_wr); #1;
        chk("cont_grant_first", wr_grant, 2'b01);
        chk("cont_awaddr0", m_awaddr, 32'h0000_0000);
        chk("cont_awready", s_awready, 2'b01);
        @(negedge clk_wr);
        s_awvalid = 2'b10; s_wvalid = 2'b10; m_bvalid = 1'b1;
        #1 chk("cont_bvalid0", s_bvalid, 2'b01);
        @(negedge clk_wr);
        m_bvalid = 1'b0;
        #1 chk("cont_grant_gap", wr_grant, 2'b00);
        @(negedge clk_wr); #1;
        chk("cont_grant_second", wr_grant, 2'b10);
        chk("cont_awaddr1", m_awaddr, 32'h0000_1111);
        chk("cont_wdata1", m_wdata, 32'hBBBB_BBBB);
        chk("cont_wready", s_wready, 2'b10);
        @(negedge clk_wr);
        s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1;
        #1 chk("cont_bvalid1", s_bvalid, 2'b10);
        @(negedge clk_wr);
        m_bvalid = 1'b0;
        #1 chk("cont_wr_cnt", wr_txn_cnt, 16'd2);

        // concurrency: port1 reads while port0 writes
        do_reset();
        @(negedge clk_wr);
        s_araddr = {32'h0000_0100, 32'h0}; s_arvalid = 2'b10; s_rready = 2'b11;
        s_awaddr = {32'h0, 32'h0000_0200}; s_wdata = {32'h0, 32'h5555_0000};
        s_wstrb = 8'h0F; s_awvalid = 2'b01; s_wvalid = 2'b01; s_bready = 2'b01;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        @(negedge clk_wr); #1;
        chk("conc_rd_grant", rd_grant, 2'b10);
        chk("conc_wr_grant", wr_grant, 2'b01);
        chk("conc_araddr", m_araddr, 32'h0000_0100);
        chk("conc_arready", s_arready, 2'b10);
        chk("conc_awaddr", m_awaddr, 32'h0000_0200);
        @(negedge clk_wr);
        s_arvalid = 2'b00; s_awvalid = 2'b00; s_wvalid = 2'b00;
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rresp = RESP_OKAY; m_bvalid = 1'b1;
        #1;
        chk("conc_rdata", s_rdata, {32'h1234_5678, 32'h0});
        chk("conc_rvalid", s_rvalid, 2'b10);
        chk("conc_bvalid", s_bvalid, 2'b01);
        chk("conc_rready", m_rready, 1'b1);
        @(negedge clk_wr);
        m_rvalid = 1'b0; m_bvalid = 1'b0;
        #1;
        chk("conc_rd_cnt", rd_txn_cnt, 16'd1);
        chk("conc_wr_cnt", wr_txn_cnt, 16'd1);

        // W before AW; slave accepts W first
        do_reset();
        aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        @(negedge clk_wr);
        s_wdata = {32'h0, 32'hCAFE_F00D}; s_wstrb = 8'h03; s_wvalid = 2'b01; s_bready = 2'b01;
        #1;
        chk("wfirst_wready_idle", s_wready, 2'b00);
        chk("wfirst_wvalid_idle", m_wvalid, 1'b0);
        repeat (2) @(negedge clk_wr);
        @(negedge clk_wr);
        s_awaddr = {32'h0, 32'h0000_0300}; s_awvalid = 2'b01;
        #1 chk("wfirst_grant_idle", wr_grant, 2'b00);
        @(negedge clk_wr);
        m_wready = 1'b1;
        #1;
        chk("wfirst_both_valid", {m_awvalid, m_wvalid}, 2'b11);
        chk("wfirst_readies", {s_awready, s_wready}, 4'b0001);
        chk("wfirst_wstrb", m_wstrb, 4'h3);
        @(negedge clk_wr);
        m_awready = 1'b1;
        #1;
        chk("wfirst_w_masked", {m_wvalid, s_wready}, 3'b000);
        chk("wfirst_awready", s_awready, 2'b01);
        chk("wfirst_state_fwd", wr_state_dbg, W_FWD);
        @(negedge clk_wr);
        s_awvalid = 2'b00; s_wvalid = 2'b00; m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1; m_bresp = RESP_SLVERR;
        #1;
        chk("wfirst_state_resp", wr_state_dbg, W_RESP);
        chk("wfirst_bresp", s_bresp, 4'b0010);
        @(negedge clk_wr);
        m_bvalid = 1'b0; m_bresp = '0;
        #1;
        chk("wfirst_aw_hs", aw_hs_n - aw0, 1);
        chk("wfirst_w_hs", w_hs_n - w0, 1);
        chk("wfirst_b_hs", b_hs_n - b0, 1);
        chk("wfirst_wr_cnt", wr_txn_cnt, 16'd1);

        // reset while waiting for B
        @(negedge clk_wr);
        s_awaddr = {32'h0, 32'h0000_0400}; s_wdata = {32'h0, 32'h0000_0044};
        s_awvalid = 2'b01; s_wvalid = 2'b01; s_bready = 2'b01;
        m_awready = 1'b1; m_wready = 1'b1;
        @(negedge clk_wr);
        @(negedge clk_wr);
        s_awvalid = 2'b00; s_wvalid = 2'b00;
        #1 chk("rstmid_in_resp", wr_state_dbg, W_RESP);
        @(negedge clk_wr);
        clear_inputs();
        rst_wr = 1'b1;
        @(negedge clk_wr);
        rst_wr = 1'b0;
        #1;
        chk("rstmid_grant", wr_grant, 2'b00);
        chk("rstmid_valids", {m_awvalid, m_wvalid, m_bready, s_bvalid}, 5'b0);
        chk("rstmid_cnts", {wr_txn_cnt, rd_txn_cnt}, 32'h0);
        chk("rstmid_state", wr_state_dbg, W_IDLE);
        wr_txn(1, 32'h0000_0500, 32'h0000_0055, RESP_OKAY, "post_rst");
        chk("post_rst_cnt", wr_txn_cnt, 16'd1);

        // counter wrap
        @(negedge clk_wr);
        force dut.wr_txn_cnt = 16'hFFFF;
        @(negedge clk_wr);
        release dut.wr_txn_cnt;
        #1 chk("wrap_preload", wr_txn_cnt, 16'hFFFF);
        wr_txn(0, 32'h0000_0600, 32'h0000_0066, RESP_OKAY, "wrap");
        chk("wrap_cnt", wr_txn_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
